// File: rtl/cmp_pair_queue.sv
// cmp_pair_queue: operand-staging FIFO in front of a combinational magnitude
// comparator. Operand pairs are queued, the head pair is presented to the
// comparator, and each pair is registered with its result into an output
// stage that uses a valid/ready handshake. Result codes: 00 equal, 01 a>b,
// 10 a<b, 11 illegal (captured result sets the sticky err flag).
module cmp_pair_queue #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic [1:0]       cmp_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [1:0]       out_r,
  output logic [CW-1:0]    count,
  output logic             err
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  // Operand storage; deliberately not reset, only the pointers/count are.
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [1:0]       out_r_q, out_r_d;
  logic             err_q, err_d;

  logic full_s;
  logic push_s;
  logic pop_s;

  // Full is judged from the count, so pointer equality never has to
  // distinguish full from empty. No write-through when full.
  assign full_s = (count_q == CW'(DEPTH));
  assign push_s = in_valid && !full_s;
  assign pop_s  = (count_q != CW'(0)) && (!out_valid_q || out_ready);

  assign in_ready  = !full_s;
  assign cmp_a     = mem_a_q[rd_ptr_q];
  assign cmp_b     = mem_b_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_r     = out_r_q;
  assign count     = count_q;
  assign err       = err_q;

  // Next-state logic for pointers, occupancy, output stage and sticky error.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_r_d     = out_r_q;
    err_d       = err_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop_s) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      out_valid_d = 1'b1;
      out_a_d     = cmp_a;
      out_b_d     = cmp_b;
      out_r_d     = cmp_r;
      if (cmp_r == 2'b11) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control and output-stage registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= PW'(0);
      rd_ptr_q    <= PW'(0);
      count_q     <= CW'(0);
      out_valid_q <= 1'b0;
      out_a_q     <= WIDTH'(0);
      out_b_q     <= WIDTH'(0);
      out_r_q     <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_r_q     <= out_r_d;
      err_q       <= err_d;
    end
  end

  // Operand storage write on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

endmodule

// File: tb/tb_cmp_pair_queue.sv
// Table-driven bench for cmp_pair_queue. Each row gives the inputs held
// across one rising edge and the outputs expected just after that edge.
// The comparator is modelled here; an override forces the illegal code.
module tb_cmp_pair_queue;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_a, in_b;
  logic [4:0] cmp_a, cmp_b;
  logic [1:0] cmp_r;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_a, out_b;
  logic [1:0] out_r;
  logic [2:0] count;
  logic       err;
  logic       force_ill;

  int errors = 0;
  int checks = 0;

  cmp_pair_queue #(.WIDTH(5), .DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_r(cmp_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_r(out_r),
    .count(count), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference comparator: 00 equal, 01 a>b, 10 a<b, forced 11 when asked.
  always_comb begin
    if (force_ill)          cmp_r = 2'b11;
    else if (cmp_a == cmp_b) cmp_r = 2'b00;
    else if (cmp_a > cmp_b)  cmp_r = 2'b01;
    else                     cmp_r = 2'b10;
  end

  typedef struct {
    logic       iv;
    logic [4:0] a;
    logic [4:0] b;
    logic       ordy;
    logic       ill;
    logic       e_ov;
    logic [4:0] e_a;
    logic [4:0] e_b;
    logic [1:0] e_r;
    logic [2:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [4:0] a, input logic [4:0] b,
                              input logic ordy, input logic ill, input logic e_ov,
                              input logic [4:0] e_a, input logic [4:0] e_b,
                              input logic [1:0] e_r, input logic [2:0] e_cnt,
                              input logic e_err);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.ordy = ordy; v.ill = ill;
    v.e_ov = e_ov; v.e_a = e_a; v.e_b = e_b; v.e_r = e_r;
    v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
    chk({tag, " out_a"},     32'(out_a),     32'(v.e_a));
    chk({tag, " out_b"},     32'(out_b),     32'(v.e_b));
    chk({tag, " out_r"},     32'(out_r),     32'(v.e_r));
    chk({tag, " count"},     32'(count),     32'(v.e_cnt));
    chk({tag, " in_ready"},  32'(in_ready),  32'(v.e_cnt != 3'd4));
    chk({tag, " err"},       32'(err),       32'(v.e_err));
  endtask

  task automatic apply_row(input string tag, input vec_t v);
    in_valid  = v.iv;
    in_a      = v.a;
    in_b      = v.b;
    out_ready = v.ordy;
    force_ill = v.ill;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    vec_t zero_v;
    // Single pair
    vecs.push_back(mk(1'b1, 5'd2,  5'd1,  1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  2'b00, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd2,  5'd1,  2'b01, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd2,  5'd1,  2'b01, 3'd0, 1'b0));
    // Streaming
    vecs.push_back(mk(1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd2,  5'd1,  2'b01, 3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd1,  5'd2,  1'b1, 1'b0, 1'b1, 5'd0,  5'd0,  2'b00, 3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd11, 5'd11, 1'b1, 1'b0, 1'b1, 5'd1,  5'd2,  2'b10, 3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd6,  5'd3,  1'b1, 1'b0, 1'b1, 5'd11, 5'd11, 2'b00, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd6,  5'd3,  2'b01, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd6,  5'd3,  2'b01, 3'd0, 1'b0));
    // Back-pressure to full; sixth pair refused
    vecs.push_back(mk(1'b1, 5'd1,  5'd1,  1'b0, 1'b0, 1'b0, 5'd6,  5'd3,  2'b01, 3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd2,  5'd3,  1'b0, 1'b0, 1'b1, 5'd1,  5'd1,  2'b00, 3'd1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd4,  5'd4,  1'b0, 1'b0, 1'b1, 5'd1,  5'd1,  2'b00, 3'd2, 1'b0));
    vecs.push_back(mk(1'b1, 5'd5,  5'd3,  1'b0, 1'b0, 1'b1, 5'd1,  5'd1,  2'b00, 3'd3, 1'b0));
    vecs.push_back(mk(1'b1, 5'd7,  5'd8,  1'b0, 1'b0, 1'b1, 5'd1,  5'd1,  2'b00, 3'd4, 1'b0));
    vecs.push_back(mk(1'b1, 5'd9,  5'd9,  1'b0, 1'b0, 1'b1, 5'd1,  5'd1,  2'b00, 3'd4, 1'b0));
    // Pop at full with push refused, then push accepted with pop
    vecs.push_back(mk(1'b1, 5'd9,  5'd9,  1'b1, 1'b0, 1'b1, 5'd2,  5'd3,  2'b10, 3'd3, 1'b0));
    vecs.push_back(mk(1'b1, 5'd9,  5'd9,  1'b1, 1'b0, 1'b1, 5'd4,  5'd4,  2'b00, 3'd3, 1'b0));
    // Drain in order
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  5'd3,  2'b01, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd7,  5'd8,  2'b10, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd9,  5'd9,  2'b00, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd9,  5'd9,  2'b00, 3'd0, 1'b0));
    // Illegal code captured; err sticky across later legal pairs
    vecs.push_back(mk(1'b1, 5'd7,  5'd10, 1'b1, 1'b0, 1'b0, 5'd9,  5'd9,  2'b00, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd7,  5'd10, 2'b11, 3'd0, 1'b1));
    vecs.push_back(mk(1'b1, 5'd3,  5'd3,  1'b1, 1'b0, 1'b0, 5'd7,  5'd10, 2'b11, 3'd1, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd3,  5'd3,  2'b00, 3'd0, 1'b1));
    // Load three pairs behind a held result before the async reset
    vecs.push_back(mk(1'b1, 5'd1,  5'd2,  1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  2'b00, 3'd1, 1'b1));
    vecs.push_back(mk(1'b1, 5'd4,  5'd5,  1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  2'b00, 3'd2, 1'b1));
    vecs.push_back(mk(1'b1, 5'd6,  5'd6,  1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  2'b00, 3'd3, 1'b1));

    zero_v = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; in_a = 5'd0; in_b = 5'd0;
    out_ready = 1'b0; force_ill = 1'b0;
    #2;
    check_outs("reset", zero_v);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) apply_row($sformatf("row%0d", i), vecs[i]);

    // Asynchronous reset between edges with pairs queued and a result held
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_outs("midreset", zero_v);
    #1 rst_n = 1'b1;

    apply_row("post0", mk(1'b1, 5'd14, 5'd14, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  2'b00, 3'd1, 1'b0));
    apply_row("post1", mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd14, 5'd14, 2'b00, 3'd0, 1'b0));
    apply_row("post2", mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd14, 5'd14, 2'b00, 3'd0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_pair_queue.md
Name: cmp_pair_queue

Overview:
- Operand-staging stage that sits directly upstream of the 5-bit magnitude comparator (combinational, a/b in, 2-bit r out).
- Buffers incoming operand pairs in a small FIFO and presents the head pair to the comparator.
- Registers each pair together with its comparator result into an output stage with a valid/ready handshake.
- Comparator result code, fixed: 2'b00 = equal, 2'b01 = a > b, 2'b10 = a < b, 2'b11 = illegal.

Parameters:
- WIDTH, 5, operand width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 3, width of occupancy count; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers a pair.
- in_ready  output  1  FIFO can accept a pair.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- cmp_a  output  WIDTH  head-entry a, driven to the comparator.
- cmp_b  output  WIDTH  head-entry b, driven to the comparator.
- cmp_r  input  2  comparator result for cmp_a/cmp_b, combinational return.
- out_valid  output  1  output stage holds a result.
- out_ready  input  1  downstream accepts the result.
- out_a  output  WIDTH  registered a.
- out_b  output  WIDTH  registered b.
- out_r  output  2  registered result code.
- count  output  CW  FIFO occupancy, 0..DEPTH; excludes the output stage.
- err  output  1  sticky flag: an illegal code was captured.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count go to 0.
  - out_valid=0; out_a, out_b and out_r go to 0.
  - err=0 and in_ready=1.
  - FIFO storage is not reset.
  - Reset mid-operation discards all queued pairs and any held result.
- in_ready = (count != DEPTH). No write-through when full, even if a pop occurs in the same cycle.
- Push: in_valid && in_ready at an edge writes {in_a, in_b} at the write pointer. The write pointer wraps modulo DEPTH.
- Head presentation:
  - cmp_a/cmp_b are driven combinationally from the read-pointer entry.
  - When count==0 they show stale storage and are don't-care.
- Capture/pop occurs when count != 0 && (!out_valid || out_ready). At that edge:
  - out_a, out_b and out_r load cmp_a, cmp_b and cmp_r.
  - out_valid is set to 1.
  - The read pointer advances, wrapping modulo DEPTH.
- Output handshake:
  - out_valid && out_ready with no capture in the same cycle clears out_valid to 0.
  - While out_valid && !out_ready, out_a/out_b/out_r hold stable.
- Simultaneous push and pop in the same cycle: count is unchanged, and both pointers advance.
- Latency:
  - A pair pushed at edge N into an empty FIFO with an empty output stage appears on out_* with out_valid=1 after edge N+1.
  - Throughput is one pair per cycle when out_ready is held high.
- Empty FIFO: no capture. out_valid falls after the held result is consumed.
- err: set when a capture loads cmp_r==2'b11. Held until reset. The illegal result is still delivered on out_r.
- Count arithmetic:
  - count increments on push-only, decrements on pop-only.
  - It never exceeds DEPTH and never underflows.
  - The full/empty distinction uses count, not pointer equality.

Test Plan:
- Reset then single pair: push a=00010, b=00001 at edge 1 with out_ready=1 -> out_valid=1 after edge 2 with out_a=00010, out_b=00001, out_r=01; count back to 0; err=0.
- Streaming: push (00000,00000), (00001,00010), (01011,01011), (00110,00011) on consecutive cycles with out_ready=1 -> out_r sequence 00,10,00,01 on consecutive cycles, one cycle behind the pushes; count never exceeds 1.
- Back-pressure/full: out_ready=0, push 6 pairs back-to-back -> first pair captured into the output stage; count reaches 4; in_ready=0 from then on; the 6th pair is not accepted. Raise out_ready -> pairs drain in order with no loss or duplication, and in_ready returns to 1 after the first pop.
- Simultaneous push/pop at full: count=4, out_valid=1, out_ready=1, in_valid=1 -> pop occurs, push is refused (in_ready=0), count=3. On the next cycle the push is accepted and count stays 3.
- Illegal code: force cmp_r=11 while the head (00111,01010) is captured -> out_r=11 and err=1; err stays 1 after subsequent legal pairs until rst_n pulses low.
- Async reset mid-stream: assert rst_n low between edges with 3 pairs queued and out_valid=1 -> immediately out_valid=0, count=0, in_ready=1, err=0. After release, a new push (01110,01110) yields out_r=00 with no residue of the old pairs.
